// File: rtl/resta_pkg.sv
// resta_pkg: shared types and constants for the subtractor result path
package resta_pkg;
  localparam int RESTA_WIDTH = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/resta_fifo_mem.sv
// resta_fifo_mem: DEPTH x DW register array, clocked write, asynchronous read
module resta_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int DW = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/registro_resultado_resta.sv
// registro_resultado_resta: result/flags capture FIFO; STICKY_FLAGS_EN adds sticky flag accumulation
module registro_resultado_resta
  import resta_pkg::*;
#(
  parameter int WIDTH = RESTA_WIDTH,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_n,
  input  logic             in_z,
  input  logic             in_c,
  input  logic             in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
`ifdef STICKY_FLAGS_EN
  input  logic             clr_sticky,
  output logic [3:0]       sticky_flags,
`endif
  output logic [CW-1:0]    count
);
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  flags_t w_in_flags;
  logic [WIDTH+3:0] w_rdata;
  assign w_in_flags = '{n: in_n, z: in_z, c: in_c, v: in_v};
  assign in_ready = r_count != CW'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  assign count = r_count;
  // head is masked to zero while empty so stale storage never shows
  assign out_y = out_valid ? w_rdata[WIDTH+3:4] : '0;
  assign out_flags = out_valid ? w_rdata[3:0] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
  end
  resta_fifo_mem #(.DEPTH(DEPTH), .DW(WIDTH + 4)) u_mem (
    .clk  (clk),
    .we   (w_push),
    .waddr(r_wptr),
    .wdata({in_y, w_in_flags}),
    .raddr(r_rptr),
    .rdata(w_rdata)
  );
`ifdef STICKY_FLAGS_EN
  logic [3:0] r_sticky;
  always_ff @(posedge clk) begin
    if (rst) r_sticky <= '0;
    else if (clr_sticky) r_sticky <= w_push ? w_in_flags : 4'b0;
    else if (w_push) r_sticky <= r_sticky | w_in_flags;
  end
  assign sticky_flags = r_sticky;
`endif
endmodule

// File: tb/tb_registro_resultado_resta.sv
// tb_registro_resultado_resta: directed self-checking bench for the result capture FIFO
module tb_registro_resultado_resta;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready;
  logic [3:0] in_y = 0;
  logic in_n = 0, in_z = 0, in_c = 0, in_v = 0;
  logic out_valid, out_ready = 0;
  logic [3:0] out_y, out_flags;
  logic [2:0] count;
`ifdef STICKY_FLAGS_EN
  logic clr_sticky = 0;
  logic [3:0] sticky_flags;
`endif
  int tests = 0, failed = 0;
  logic [7:0] exp_q [$];
  logic [7:0] head;
  logic [3:0] fill_y [4] = '{4'h7, 4'h0, 4'hE, 4'hF};
  logic [3:0] fill_f [4] = '{4'b0001, 4'b0100, 4'b1010, 4'b1010};

  registro_resultado_resta dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags),
`ifdef STICKY_FLAGS_EN
    .clr_sticky(clr_sticky), .sticky_flags(sticky_flags),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] y, input logic [3:0] f);
    in_valid = v;
    in_y = y;
    {in_n, in_z, in_c, in_v} = f;
  endtask

  initial begin
    step();
    step();
    rst = 0;
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_y", 8'(out_y), 8'd0);
    chk("rst_out_flags", 8'(out_flags), 8'd0);
    step();
    chk("idle_count", 8'(count), 8'd0);
    // single push of 3-5
    drive(1, 4'hE, 4'b1010);
    chk("push_not_visible_yet", 8'(out_valid), 8'd0);
    step();
    drive(0, 4'h3, 4'b1111);
    chk("single_valid", 8'(out_valid), 8'd1);
    chk("single_y", 8'(out_y), 8'h0E);
    chk("single_flags", 8'(out_flags), 8'b1010);
    chk("single_count", 8'(count), 8'd1);
    step();
    chk("ignored_invalid_count", 8'(count), 8'd1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("single_pop_count", 8'(count), 8'd0);
    chk("single_pop_valid", 8'(out_valid), 8'd0);
    chk("single_pop_y", 8'(out_y), 8'd0);
    out_ready = 1;
    step();
    chk("empty_pop_count", 8'(count), 8'd0);
    out_ready = 0;
    // fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1, fill_y[i], fill_f[i]);
      step();
    end
    chk("full_count", 8'(count), 8'd4);
    chk("full_in_ready", 8'(in_ready), 8'd0);
    drive(1, 4'h3, 4'b1111);
    step();
    drive(0, 4'h0, 4'b0000);
    chk("full_reject_count", 8'(count), 8'd4);
    chk("full_hold_y", 8'(out_y), 8'h07);
    chk("full_hold_flags", 8'(out_flags), 8'b0001);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_y%0d", i), 8'(out_y), 8'(fill_y[i]));
      chk($sformatf("drain_f%0d", i), 8'(out_flags), 8'(fill_f[i]));
      step();
      if (i == 0) begin
        chk("after_full_pop_count", 8'(count), 8'd3);
        chk("after_full_pop_ready", 8'(in_ready), 8'd1);
      end
    end
    out_ready = 0;
    chk("drained_count", 8'(count), 8'd0);
    chk("drained_valid", 8'(out_valid), 8'd0);
    // simultaneous push/pop at count=2, across wrap
    for (int i = 1; i <= 2; i++) begin
      drive(1, 4'(i), 4'(i * 5));
      exp_q.push_back({4'(i), 4'(i * 5)});
      step();
    end
    chk("pp_start_count", 8'(count), 8'd2);
    out_ready = 1;
    for (int i = 3; i <= 8; i++) begin
      drive(1, 4'(i), 4'(i * 5));
      exp_q.push_back({4'(i), 4'(i * 5)});
      head = exp_q.pop_front();
      chk($sformatf("pp_head%0d", i), {out_y, out_flags}, head);
      step();
      chk($sformatf("pp_count%0d", i), 8'(count), 8'd2);
    end
    drive(0, 4'h0, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      head = exp_q.pop_front();
      chk($sformatf("pp_tail%0d", i), {out_y, out_flags}, head);
      step();
    end
    out_ready = 0;
    chk("pp_end_count", 8'(count), 8'd0);
    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(9 + i), 4'b0110);
      step();
    end
    drive(0, 4'h0, 4'b0000);
    chk("mid_count", 8'(count), 8'd3);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_count", 8'(count), 8'd0);
    chk("mid_rst_valid", 8'(out_valid), 8'd0);
    chk("mid_rst_out", {out_y, out_flags}, 8'd0);
    out_ready = 1;
    step();
    step();
    chk("mid_rst_no_stale", 8'(out_valid), 8'd0);
    out_ready = 0;
`ifdef STICKY_FLAGS_EN
    chk("sticky_rst", 8'(sticky_flags), 8'd0);
    drive(1, 4'h7, 4'b0001);
    step();
    drive(1, 4'hE, 4'b1010);
    step();
    drive(0, 4'h0, 4'b0000);
    chk("sticky_or", 8'(sticky_flags), 8'b1011);
    clr_sticky = 1;
    drive(1, 4'h0, 4'b0100);
    step();
    clr_sticky = 0;
    drive(0, 4'h0, 4'b0000);
    chk("sticky_clr_push", 8'(sticky_flags), 8'b0100);
    clr_sticky = 1;
    step();
    clr_sticky = 0;
    chk("sticky_clr_only", 8'(sticky_flags), 8'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/registro_resultado_resta.md
Name: registro_resultado_resta

Overview:
Downstream capture stage for the 4-bit circular subtractor. It registers each result word Y and its NZCV flags, presented as a valid/ready handshake, into a small FIFO. It delivers them in order to the consumer (display/controller) over an output valid/ready handshake. An occupancy count is exported for status LEDs.

Parameters:
WIDTH, 4, result width; must match the subtractor data width.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream has a result/flags word
in_ready  out  1  stage can accept a word this cycle
in_y  in  WIDTH  subtractor result Y
in_n  in  1  negative flag
in_z  in  1  zero flag
in_c  in  1  borrow flag (1 = borrow occurred)
in_v  in  1  signed overflow flag
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_y  out  WIDTH  head result
out_flags  out  4  head flags packed {N,Z,C,V}, bit 3 = N
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at clk edge): write/read pointers=0, count=0, out_valid=0, in_ready=1, out_y=0, out_flags=0. Storage contents are don't-care.
- Push: when in_valid && in_ready, write {in_y, flags} at the write pointer. The write pointer increments mod DEPTH.
- Pop: when out_valid && out_ready, the read pointer increments mod DEPTH.
- in_ready = (count != DEPTH), combinational from registered count. There is no push-when-full bypass.
- out_valid = (count != 0). out_y/out_flags are driven from the head entry. When empty they hold 0.
- Latency: a word pushed into an empty FIFO is visible on out_* in the cycle after the push edge (1 cycle). There is no same-cycle fall-through.
- Simultaneous push and pop (0 < count < DEPTH): both occur and count is unchanged.
- Full: pop only; count goes DEPTH→DEPTH-1 and in_ready rises next cycle.
- Empty: a pop request is ignored, because out_valid=0.
- Count transitions:
  - EMPTY (count=0) → PARTIAL on push.
  - PARTIAL → EMPTY on pop-only at count=1.
  - PARTIAL → FULL on push-only at count=DEPTH-1.
  - FULL → PARTIAL on pop.
- Pointers use log2(DEPTH) bits and wrap naturally; the count register disambiguates full from empty.
- Data on in_* while in_valid=0 is ignored. out_* must stay stable while out_valid && !out_ready.
- Reset mid-operation: all stored entries are discarded and outputs return to reset values on the next edge. No partial entry survives.

Optional Feature:
Macro STICKY_FLAGS_EN.
- Defined: adds an input clr_sticky (1 bit) and an output sticky_flags (4 bits, {N,Z,C,V}).
  - On every accepted push, sticky_flags |= pushed flags.
  - clr_sticky=1 at the clock edge sets sticky_flags to the flags of any push in that same cycle, or 0 if there is no push.
  - Reset value is 0.
- Undefined: neither port nor register exists. Behaviour is otherwise identical.

Decomposition:
- Shared package resta_pkg:
  - flags_t packed struct {n,z,c,v}, 4 bits.
  - localparam RESTA_WIDTH=4.
  - Flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module, resta_fifo_mem: a DEPTH x (WIDTH+4) register array with one write port (clocked, we/waddr/wdata) and one asynchronous read port (raddr/rdata).
- Pointer, count and handshake logic stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → count=0, out_valid=0, in_ready=1, out_y=0, out_flags=0.
- Single push of the 3-5 result: Y=0xE, flags {1,0,1,0} → next cycle out_valid=1, out_y=0xE, out_flags=4'b1010. With out_ready=1 → next cycle count=0, out_valid=0.
- Fill to full with out_ready=0:
  - Pushes: 8-1 (Y=0x7, {0,0,0,1}); 5-5 (Y=0x0, {0,1,0,0}); 3-5; 0-1 (Y=0xF, {1,0,1,0}).
  - Expected: count=4, in_ready=0, and a fifth in_valid is not accepted.
  - Drain → order 0x7, 0x0, 0xE, 0xF with matching flags.
- Simultaneous push/pop at count=2 for 6 cycles → count stays 2, and the output sequence matches input order across pointer wrap-around.
- Reset asserted at count=3 mid-stream → next cycle count=0, out_valid=0, and nothing stale is emitted afterwards.
- STICKY_FLAGS_EN build:
  - Push {0,0,0,1}, then {1,0,1,0} → sticky_flags=4'b1011.
  - Assert clr_sticky together with a push of {0,1,0,0} → sticky_flags=4'b0100.
